// File: rtl/vga_80x60_pkg.sv
// Shared types for the 80x60 VGA framebuffer: geometry, packed write address,
// RGB332 pixel and the rectangle-fill state encoding.
package vga_80x60_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    typedef logic [12:0] fb_addr_t;
    typedef logic [7:0]  rgb332_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } fill_state_t;

    // Row-major with a 128-cell stride: {row[5:0], col[6:0]}.
    function automatic fb_addr_t fb_addr(input logic [5:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vga_rect_fill_80x60_if.sv
// Command, CPU write-port and framebuffer write-port bundle for the fill engine.
interface vga_rect_fill_80x60_if;
    import vga_80x60_pkg::*;

    // START is a one-cycle request taken only while BUSY=0; a START seen
    // while BUSY=1 is dropped. DONE pulses for one cycle at the end of each
    // accepted command. CPU_WE always wins the framebuffer port that cycle.
    logic        START;
    logic [6:0]  X0;
    logic [5:0]  Y0;
    logic [6:0]  X1;
    logic [5:0]  Y1;
    rgb332_t     COLOR;
    fb_addr_t    CPU_WA;
    rgb332_t     CPU_WD;
    logic        CPU_WE;
    fb_addr_t    FB_WA;
    rgb332_t     FB_WD;
    logic        FB_WE;
    logic        BUSY;
    logic        DONE;
    fill_state_t state;

    modport slave (
        input  START, X0, Y0, X1, Y1, COLOR, CPU_WA, CPU_WD, CPU_WE,
        output FB_WA, FB_WD, FB_WE, BUSY, DONE, state
    );

    modport master (
        output START, X0, Y0, X1, Y1, COLOR, CPU_WA, CPU_WD, CPU_WE,
        input  FB_WA, FB_WD, FB_WE, BUSY, DONE, state
    );

endinterface

// File: rtl/vga_rect_fill_80x60.sv
// Rectangle-fill engine in front of the 80x60 framebuffer write port; writes
// one cell per cycle and yields the port to CPU writes whenever CPU_WE=1.
module vga_rect_fill_80x60
    import vga_80x60_pkg::*;
(
    input  logic                   CLK_50MHz,
    input  logic                   RST_N,
    vga_rect_fill_80x60_if.slave   bus
);

    fill_state_t state, state_nx;
    logic [6:0]  cx, cx_nx, x0_q, x0_nx, x1c_q, x1c_nx;
    logic [5:0]  cy, cy_nx, y1c_q, y1c_nx;
    rgb332_t     color, color_nx;

    logic [6:0]  x1c;
    logic [5:0]  y1c;
    logic        empty;

    // Clip the far corner to the visible area, then reject inverted or off-screen boxes.
    always_comb begin
        x1c   = (bus.X1 > COL_LAST) ? COL_LAST : bus.X1;
        y1c   = (bus.Y1 > ROW_LAST) ? ROW_LAST : bus.Y1;
        empty = (bus.X0 > COL_LAST) || (bus.Y0 > ROW_LAST) ||
                (bus.X0 > x1c)      || (bus.Y0 > y1c);
    end

    always_ff @(posedge CLK_50MHz) begin
        if (!RST_N) begin
            state <= IDLE;
            cx    <= '0;
            cy    <= '0;
            color <= '0;
            x0_q  <= '0;
            x1c_q <= '0;
            y1c_q <= '0;
        end else begin
            state <= state_nx;
            cx    <= cx_nx;
            cy    <= cy_nx;
            color <= color_nx;
            x0_q  <= x0_nx;
            x1c_q <= x1c_nx;
            y1c_q <= y1c_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cx_nx    = cx;
        cy_nx    = cy;
        color_nx = color;
        x0_nx    = x0_q;
        x1c_nx   = x1c_q;
        y1c_nx   = y1c_q;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    color_nx = bus.COLOR;
                    x0_nx    = bus.X0;
                    x1c_nx   = x1c;
                    y1c_nx   = y1c;
                    if (empty) begin
                        state_nx = FIN;
                    end else begin
                        cx_nx    = bus.X0;
                        cy_nx    = bus.Y0;
                        state_nx = FILL;
                    end
                end
            end
            FILL: begin
                // A CPU write owns the port this cycle, so the raster position holds.
                if (!bus.CPU_WE) begin
                    if (cx == x1c_q && cy == y1c_q) begin
                        state_nx = FIN;
                    end else if (cx == x1c_q) begin
                        cx_nx = x0_q;
                        cy_nx = cy + 6'd1;
                    end else begin
                        cx_nx = cx + 7'd1;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        if (bus.CPU_WE || state != FILL) begin
            bus.FB_WA = bus.CPU_WA;
            bus.FB_WD = bus.CPU_WD;
            bus.FB_WE = bus.CPU_WE;
        end else begin
            bus.FB_WA = fb_addr(cy, cx);
            bus.FB_WD = color;
            bus.FB_WE = 1'b1;
        end
        bus.BUSY  = (state != IDLE);
        bus.DONE  = (state == FIN);
        bus.state = state;
    end

endmodule

// File: tb/tb_vga_rect_fill_80x60.sv
// Directed bench for the rectangle-fill engine: table of fill commands with
// hand-computed results, plus reset and abort sequences.
module tb_vga_rect_fill_80x60;
  import vga_80x60_pkg::*;

  logic CLK_50MHz;
  logic RST_N;
  vga_rect_fill_80x60_if bus ();

  vga_rect_fill_80x60 dut (
    .CLK_50MHz(CLK_50MHz),
    .RST_N    (RST_N),
    .bus      (bus)
  );

  // clock / reset
  initial CLK_50MHz = 1'b0;
  always #10 CLK_50MHz = ~CLK_50MHz;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  typedef struct {
    logic [6:0]  x0;
    logic [5:0]  y0;
    logic [6:0]  x1;
    logic [5:0]  y1;
    logic [7:0]  color;
    int          cpu_cyc;     // -2 none, -1 same cycle as START, else cycle index
    int          restart_cyc; // -1 none
    int          exp_n;
    logic [12:0] exp_first;
    logic [12:0] exp_last;
    int          exp_done;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic drive_idle();
    bus.START  = 1'b0;
    bus.X0     = '0;
    bus.Y0     = '0;
    bus.X1     = '0;
    bus.Y1     = '0;
    bus.COLOR  = '0;
    bus.CPU_WA = '0;
    bus.CPU_WD = '0;
    bus.CPU_WE = 1'b0;
  endtask

  // Expected write addresses, straight from the clipping rule.
  task automatic build_model(input vec_t v);
    int x1c, y1c;
    exp_q.delete();
    x1c = (int'(v.x1) > COLS - 1) ? COLS - 1 : int'(v.x1);
    y1c = (int'(v.y1) > ROWS - 1) ? ROWS - 1 : int'(v.y1);
    if (int'(v.x0) <= x1c && int'(v.y0) <= y1c) begin
      for (int r = int'(v.y0); r <= y1c; r++)
        for (int c = int'(v.x0); c <= x1c; c++)
          exp_q.push_back({6'(r), 7'(c)});
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n_wr;
    int done_at;
    logic cpu_now;
    logic [12:0] a, first_a, last_a;
    build_model(v);
    n_wr = 0;
    done_at = -1;
    first_a = '0;
    last_a = '0;
    @(negedge CLK_50MHz);
    bus.START = 1'b1;
    bus.X0 = v.x0; bus.Y0 = v.y0; bus.X1 = v.x1; bus.Y1 = v.y1;
    bus.COLOR = v.color;
    if (v.cpu_cyc == -1) begin
      bus.CPU_WE = 1'b1; bus.CPU_WA = 13'h0005; bus.CPU_WD = 8'h55;
      #1;
      check($sformatf("v%0d start_cpu_we", idx), 32'(bus.FB_WE), 32'd1);
      check($sformatf("v%0d start_cpu_wa", idx), 32'(bus.FB_WA), 32'h0005);
    end
    @(posedge CLK_50MHz);
    #1;
    for (int c = 0; c <= v.exp_done + 1; c++) begin
      cpu_now = (c == v.cpu_cyc);
      bus.CPU_WE = cpu_now;
      bus.CPU_WA = 13'h0005;
      bus.CPU_WD = 8'h55;
      if (c == v.restart_cyc) begin
        bus.START = 1'b1;
        bus.X0 = 7'd0; bus.Y0 = 6'd0; bus.X1 = 7'd127; bus.Y1 = 6'd63;
        bus.COLOR = 8'hFF;
      end else begin
        bus.START = 1'b0;
      end
      @(negedge CLK_50MHz);
      if (cpu_now) begin
        check($sformatf("v%0d cpu_pass_we", idx), 32'(bus.FB_WE), 32'd1);
        check($sformatf("v%0d cpu_pass_wa", idx), 32'(bus.FB_WA), 32'h0005);
        check($sformatf("v%0d cpu_pass_wd", idx), 32'(bus.FB_WD), 32'h55);
      end else if (bus.FB_WE) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d extra_write", idx), 32'(bus.FB_WA), 32'h1FFFF);
        end else begin
          a = exp_q.pop_front();
          check($sformatf("v%0d wr_addr", idx), 32'(bus.FB_WA), 32'(a));
          check($sformatf("v%0d wr_data", idx), 32'(bus.FB_WD), 32'(v.color));
          if (bus.FB_WA[6:0] > 7'd79)
            check($sformatf("v%0d col_range", idx), 32'(bus.FB_WA[6:0]), 32'd79);
        end
        if (n_wr == 1) first_a = bus.FB_WA;
        last_a = bus.FB_WA;
      end
      if (bus.DONE && done_at < 0) done_at = c;
      if (c <= v.exp_done) begin
        if (!bus.BUSY) check($sformatf("v%0d busy_hi c%0d", idx, c), 32'(bus.BUSY), 32'd1);
      end else begin
        check($sformatf("v%0d busy_lo", idx), 32'(bus.BUSY), 32'd0);
        check($sformatf("v%0d done_lo", idx), 32'(bus.DONE), 32'd0);
      end
      @(posedge CLK_50MHz);
      #1;
    end
    bus.START = 1'b0;
    bus.CPU_WE = 1'b0;
    check($sformatf("v%0d write_count", idx), 32'(n_wr), 32'(v.exp_n));
    check($sformatf("v%0d done_cycle", idx), 32'(done_at), 32'(v.exp_done));
    if (v.exp_n > 0) begin
      check($sformatf("v%0d first_addr", idx), 32'(first_a), 32'(v.exp_first));
      check($sformatf("v%0d last_addr", idx), 32'(last_a), 32'(v.exp_last));
    end
  endtask

  initial begin
    vec_t rv;
    //            x0  y0  x1   y1  color  cpu  rst  n     first     last      done
    vecs[0]  = '{7'd2,  6'd3,  7'd4,   6'd4,  8'hE0, -2, -1, 6,    13'h0182, 13'h0204, 6};
    vecs[1]  = '{7'd0,  6'd0,  7'd127, 6'd63, 8'h1C, -2, -1, 4800, 13'h0000, 13'h1DCF, 4800};
    vecs[2]  = '{7'd10, 6'd10, 7'd11,  6'd10, 8'h3A,  1, -1, 2,    13'h050A, 13'h050B, 3};
    vecs[3]  = '{7'd90, 6'd0,  7'd100, 6'd5,  8'h11, -2, -1, 0,    13'h0000, 13'h0000, 0};
    vecs[4]  = '{7'd5,  6'd0,  7'd3,   6'd5,  8'h22, -2, -1, 0,    13'h0000, 13'h0000, 0};
    vecs[5]  = '{7'd78, 6'd58, 7'd100, 6'd63, 8'h03, -2, -1, 4,    13'h1D4E, 13'h1DCF, 4};
    vecs[6]  = '{7'd20, 6'd5,  7'd22,  6'd6,  8'h6C, -2,  2, 6,    13'h0294, 13'h0316, 6};
    vecs[7]  = '{7'd0,  6'd0,  7'd3,   6'd0,  8'h81, -1, -1, 4,    13'h0000, 13'h0003, 4};
    vecs[8]  = '{7'd1,  6'd1,  7'd2,   6'd1,  8'h99,  2, -1, 2,    13'h0081, 13'h0082, 2};
    vecs[9]  = '{7'd79, 6'd59, 7'd79,  6'd59, 8'hC3, -2, -1, 1,    13'h1DCF, 13'h1DCF, 1};
    vecs[10] = '{7'd0,  6'd60, 7'd10,  6'd63, 8'h44, -2, -1, 0,    13'h0000, 13'h0000, 0};

    drive_idle();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK_50MHz);
    #1;
    bus.CPU_WE = 1'b1; bus.CPU_WA = 13'h1234; bus.CPU_WD = 8'hA5;
    @(negedge CLK_50MHz);
    check("rst busy", 32'(bus.BUSY), 32'd0);
    check("rst done", 32'(bus.DONE), 32'd0);
    check("rst pass_we", 32'(bus.FB_WE), 32'd1);
    check("rst pass_wa", 32'(bus.FB_WA), 32'h1234);
    check("rst pass_wd", 32'(bus.FB_WD), 32'hA5);
    @(posedge CLK_50MHz);
    #1;
    bus.CPU_WE = 1'b0;
    RST_N = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset for one edge in the middle of a one-row fill.
    @(negedge CLK_50MHz);
    bus.START = 1'b1;
    bus.X0 = 7'd0; bus.Y0 = 6'd0; bus.X1 = 7'd79; bus.Y1 = 6'd0; bus.COLOR = 8'h5A;
    @(posedge CLK_50MHz);
    #1;
    bus.START = 1'b0;
    repeat (5) @(posedge CLK_50MHz);
    #1;
    check("abort pre_busy", 32'(bus.BUSY), 32'd1);
    RST_N = 1'b0;
    @(posedge CLK_50MHz);
    #1;
    RST_N = 1'b1;
    for (int c = 0; c < 90; c++) begin
      bus.CPU_WE = (c % 5 == 0);
      bus.CPU_WA = 13'(c);
      bus.CPU_WD = 8'(c + 1);
      @(negedge CLK_50MHz);
      if (bus.FB_WE !== bus.CPU_WE || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
        check($sformatf("abort c%0d we/busy/done", c),
              {29'd0, bus.FB_WE, bus.BUSY, bus.DONE}, {29'd0, bus.CPU_WE, 2'b00});
      else
        n_cmp++;
      if (bus.CPU_WE) check($sformatf("abort c%0d wa", c), 32'(bus.FB_WA), 32'(c));
      @(posedge CLK_50MHz);
      #1;
    end
    bus.CPU_WE = 1'b0;

    rv = '{7'd0, 6'd0, 7'd79, 6'd0, 8'h5A, -2, -1, 80, 13'h0000, 13'h004F, 80};
    run_vec(11, rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
